// File: rtl/ext_bus_target.sv
// Byte-serial external bus target: decodes READ/WRITE frames against a local word memory
// and streams back ACK, NAK or RDATA+data with parity on every beat.
module ext_bus_target #(
    parameter int unsigned BUS_W      = 8,
    parameter int unsigned ADDR_BYTES = 4,
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [BUS_W-1:0] ext_bus_in,
    input  logic             ext_bus_pty_in,
    output logic [BUS_W-1:0] ext_bus_out,
    output logic             ext_bus_pty_out,
    output logic             busy,
    output logic [7:0]       err_count
);

    localparam int unsigned ADDR_W     = ADDR_BYTES * 8;
    localparam int unsigned DATA_W     = DATA_BYTES * 8;
    localparam int unsigned ADDR_BEATS = ADDR_W / BUS_W;
    localparam int unsigned DATA_BEATS = DATA_W / BUS_W;
    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
    localparam int unsigned OFF_W      = $clog2(DATA_BYTES);
    localparam int unsigned CMP_W      = ((ADDR_W > 32) ? ADDR_W : 32) + 1;

    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_WRITE = 8'h03;
    localparam logic [7:0] RSP_ACK   = 8'h83;
    localparam logic [7:0] RSP_RDATA = 8'h82;
    localparam logic [7:0] RSP_NAK   = 8'h84;

    localparam logic [CMP_W-1:0] WIN_LO = CMP_W'(BASE_ADDR);
    localparam logic [CMP_W-1:0] WIN_HI = WIN_LO + CMP_W'(MEM_DEPTH * DATA_BYTES);

    typedef enum logic [2:0] {StIdle, StAddr, StSel, StData, StResp} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              beat_q, beat_d;
    logic                    is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_BYTES-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [7:0]              tx_rem_q, tx_rem_d;
    logic [DATA_W-1:0]       tx_buf_q, tx_buf_d;
    logic [BUS_W-1:0]        out_q, out_d;
    logic                    pty_q;
    logic [7:0]              err_q, err_d;
    logic [DATA_W-1:0]       mem [MEM_DEPTH];

    logic                    pty_ok, cmd_rd, cmd_wr, upper_zero, drop, mem_we, hit;
    logic [ADDR_W-1:0]       addr_shift;
    logic [DATA_W-1:0]       data_shift;
    logic [CMP_W-1:0]        addr_ext, offset;
    logic [IDX_W-1:0]        idx;

    assign pty_ok     = (ext_bus_pty_in == ~^ext_bus_in);
    assign upper_zero = ((ext_bus_in >> 8) == '0);
    assign cmd_rd     = upper_zero && (ext_bus_in[7:0] == CMD_READ);
    assign cmd_wr     = upper_zero && (ext_bus_in[7:0] == CMD_WRITE);

    // Fields arrive LS beat first, so each new beat enters at the top and shifts down.
    assign addr_shift = (addr_q >> BUS_W) | (ADDR_W'(ext_bus_in) << (ADDR_W - BUS_W));
    assign data_shift = (data_q >> BUS_W) | (DATA_W'(ext_bus_in) << (DATA_W - BUS_W));

    assign addr_ext = CMP_W'(addr_q);
    assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign offset   = addr_ext - WIN_LO;
    assign idx      = offset[OFF_W +: IDX_W];

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        data_d   = data_q;
        tx_rem_d = tx_rem_q;
        tx_buf_d = tx_buf_q;
        out_d    = '0;
        mem_we   = 1'b0;
        drop     = 1'b0;
        err_d    = err_q;

        // Queued beats drain independently of the request side, even across parity errors.
        if (tx_rem_q != '0) begin
            out_d    = tx_buf_q[BUS_W-1:0];
            tx_buf_d = tx_buf_q >> BUS_W;
            tx_rem_d = tx_rem_q - 8'd1;
        end

        if (!pty_ok) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_rd || cmd_wr) begin
                        if (tx_rem_q != '0) begin
                            drop = 1'b1;
                        end else begin
                            state_d = StAddr;
                            beat_d  = '0;
                            is_wr_d = cmd_wr;
                        end
                    end
                end
                StAddr: begin
                    addr_d = addr_shift;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == 8'(ADDR_BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = is_wr_q ? StSel : StResp;
                    end
                end
                StSel: begin
                    sel_d   = ext_bus_in[DATA_BYTES-1:0];
                    beat_d  = '0;
                    state_d = StData;
                end
                StData: begin
                    data_d = data_shift;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == 8'(DATA_BEATS - 1)) begin
                        mem_we  = hit;
                        state_d = StResp;
                    end
                end
                StResp: begin
                    state_d = StIdle;
                    if (!hit) begin
                        out_d = BUS_W'(RSP_NAK);
                    end else if (is_wr_q) begin
                        out_d = BUS_W'(RSP_ACK);
                    end else begin
                        out_d    = BUS_W'(RSP_RDATA);
                        tx_rem_d = 8'(DATA_BEATS);
                        tx_buf_d = mem[idx];
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if ((!pty_ok || drop) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            tx_rem_q <= '0;
            tx_buf_q <= '0;
            out_q    <= '0;
            pty_q    <= 1'b1;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            tx_rem_q <= tx_rem_d;
            tx_buf_q <= tx_buf_d;
            out_q    <= out_d;
            pty_q    <= ~^out_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset; writes are gated by the reset FSM state.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(DATA_BYTES); b++) begin
            if (mem_we && sel_q[b]) begin
                mem[idx][b*8 +: 8] <= data_shift[b*8 +: 8];
            end
        end
    end

    assign ext_bus_out     = out_q;
    assign ext_bus_pty_out = pty_q;
    assign err_count       = err_q;
    assign busy            = (state_q != StIdle) || (tx_rem_q != '0);

endmodule

// File: tb/tb_ext_bus_target.sv
// Bench for ext_bus_target: an 8-bit and a 16-bit instance checked every cycle against a
// frame-level model (word array plus expected-response queues).
module tb_ext_bus_target;

    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [7:0]  in0 = '0;
    logic        pi0 = 1'b1;
    logic [15:0] in1 = '0;
    logic        pi1 = 1'b1;
    logic [7:0]  out0, err0;
    logic [15:0] out1;
    logic [7:0]  err1;
    logic        po0, po1, busy0, busy1;

    int          n_tests = 0;
    int          n_fail = 0;
    int          stepn = 0;
    int          em [2];
    int          rs [2];
    int          rl [2];
    logic [63:0] mdl [2][16];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    always #5 clk = ~clk;

    ext_bus_target #(.BUS_W(8)) u_dut8 (
        .clk(clk), .resetb(resetb), .ext_bus_in(in0), .ext_bus_pty_in(pi0),
        .ext_bus_out(out0), .ext_bus_pty_out(po0), .busy(busy0), .err_count(err0)
    );

    ext_bus_target #(.BUS_W(16)) u_dut16 (
        .clk(clk), .resetb(resetb), .ext_bus_in(in1), .ext_bus_pty_in(pi1),
        .ext_bus_out(out1), .ext_bus_pty_out(po1), .busy(busy1), .err_count(err1)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input int inst, input logic [15:0] v);
        if (inst == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    function automatic int qsize(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    // One bus cycle: check both instances' outputs, then drive the next input beat.
    task automatic step(input int inst, input logic [15:0] v, input bit bad, input bit drop);
        logic [15:0] e0, e1;
        @(negedge clk);
        stepn++;
        e0 = (q0.size() > 0) ? q0.pop_front() : 16'h0;
        e1 = (q1.size() > 0) ? q1.pop_front() : 16'h0;
        chk("out0", 64'(out0), 64'(e0[7:0]));
        chk("pty0", 64'(po0), 64'(~^e0[7:0]));
        chk("err0", 64'(err0), 64'(em[0]));
        chk("out1", 64'(out1), 64'(e1));
        chk("pty1", 64'(po1), 64'(~^e1));
        chk("err1", 64'(err1), 64'(em[1]));
        in0 = '0; pi0 = 1'b1; in1 = '0; pi1 = 1'b1;
        if (inst == 0) begin
            in0 = v[7:0];
            pi0 = bad ? ^v[7:0] : ~^v[7:0];
        end else begin
            in1 = v;
            pi1 = bad ? ^v : ~^v;
        end
        if (bad || drop) em[inst] = (em[inst] >= 255) ? 255 : em[inst] + 1;
    endtask

    task automatic drain(input int inst);
        while (qsize(inst) > 0) step(inst, 16'h0, 1'b0, 1'b0);
    endtask

    // Sends one frame; bad_at is the beat index carrying bad parity (-1 for none).
    task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                        input logic [7:0] sel, input logic [63:0] data, input int bad_at);
        int          bw, ab, db, s, widx, len;
        logic [15:0] mask;
        logic [15:0] beats [$];
        logic [31:0] off;
        bit          hit;
        bw   = (inst == 0) ? 8 : 16;
        ab   = 32 / bw;
        db   = 64 / bw;
        mask = (inst == 0) ? 16'h00FF : 16'hFFFF;
        s    = stepn + 1;
        if (s >= rs[inst] + 2 && s <= rs[inst] + rl[inst]) begin
            step(inst, wr ? 16'h3 : 16'h2, bad_at == 0, 1'b1);
            return;
        end
        beats.push_back(wr ? 16'h3 : 16'h2);
        for (int i = 0; i < ab; i++) beats.push_back(16'(addr >> (i * bw)) & mask);
        if (wr) begin
            beats.push_back({8'h0, sel});
            for (int i = 0; i < db; i++) beats.push_back(16'(data >> (i * bw)) & mask);
        end
        for (int i = 0; i < beats.size(); i++) begin
            step(inst, beats[i], i == bad_at, 1'b0);
            if (i == bad_at) return;
        end
        hit  = (addr >= BASE) && (addr < BASE + 32'd128);
        off  = addr - BASE;
        widx = int'(off[6:3]);
        len  = 1;
        push(inst, 16'h0);
        if (!hit) begin
            push(inst, 16'h0084);
        end else if (wr) begin
            for (int b = 0; b < 8; b++) if (sel[b]) mdl[inst][widx][b*8 +: 8] = data[b*8 +: 8];
            push(inst, 16'h0083);
        end else begin
            push(inst, 16'h0082);
            for (int i = 0; i < db; i++) push(inst, 16'(mdl[inst][widx] >> (i * bw)) & mask);
            len = 1 + db;
        end
        rs[inst] = stepn;
        rl[inst] = len;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin em[i] = 0; rs[i] = -100; rl[i] = 0; end

        repeat (2) @(negedge clk);
        chk("rst_out0", 64'(out0), 64'h0);   chk("rst_pty0", 64'(po0), 64'h1);
        chk("rst_busy0", 64'(busy0), 64'h0); chk("rst_err0", 64'(err0), 64'h0);
        chk("rst_out1", 64'(out1), 64'h0);   chk("rst_pty1", 64'(po1), 64'h1);
        chk("rst_busy1", 64'(busy1), 64'h0); chk("rst_err1", 64'(err1), 64'h0);
        resetb = 1'b1;

        // Directed full write, read, partial write, out-of-window accesses.
        xfer(0, 1'b1, 32'h10, 8'hFF, 64'h1122334455667788, -1); drain(0);
        xfer(0, 1'b0, 32'h10, 8'h00, 64'h0, -1); drain(0);
        xfer(0, 1'b1, 32'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, -1); drain(0);
        xfer(0, 1'b0, 32'h10, 8'h00, 64'h0, -1); drain(0);
        chk("partial_model", mdl[0][2], 64'h11223344AAAAAAAA);
        xfer(0, 1'b1, 32'h100, 8'hFF, 64'hDEADBEEFDEADBEEF, -1); drain(0);
        xfer(0, 1'b0, 32'h100, 8'h00, 64'h0, -1); drain(0);
        xfer(0, 1'b0, 32'h10, 8'h00, 64'h0, -1); drain(0);

        // Parity error on the second address beat aborts the frame.
        xfer(0, 1'b1, 32'h20, 8'hFF, 64'h0102030405060708, 2);
        step(0, 16'h0, 1'b0, 1'b0);
        chk("busy_after_abort", 64'(busy0), 64'h0);
        xfer(0, 1'b1, 32'h20, 8'hFF, 64'h0102030405060708, -1); drain(0);
        xfer(0, 1'b0, 32'h20, 8'h00, 64'h0, -1); drain(0);

        // Commands during a streaming read response are dropped; first free cycle accepts.
        xfer(0, 1'b0, 32'h10, 8'h00, 64'h0, -1);
        repeat (3) step(0, 16'h0, 1'b0, 1'b0);
        xfer(0, 1'b1, 32'h18, 8'hFF, 64'h5555666677778888, -1);
        chk("busy_stream", 64'(busy0), 64'h1);
        repeat (4) step(0, 16'h0, 1'b0, 1'b0);
        xfer(0, 1'b1, 32'h18, 8'hFF, 64'h5555666677778888, 0);
        xfer(0, 1'b1, 32'h18, 8'hFF, 64'h5555666677778888, -1); drain(0);
        xfer(0, 1'b0, 32'h18, 8'h00, 64'h0, -1); drain(0);

        // 16-bit instance directed write/read.
        xfer(1, 1'b1, 32'h18, 8'hFF, 64'hCAFEF00D12345678, -1); drain(1);
        xfer(1, 1'b0, 32'h18, 8'h00, 64'h0, -1); drain(1);

        // Randomized traffic on both instances after defining every word.
        for (int inst = 0; inst < 2; inst++) begin
            for (int w = 0; w < 16; w++) begin
                xfer(inst, 1'b1, 32'(w * 8), 8'hFF, {$urandom, $urandom}, -1); drain(inst);
            end
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 9) < 8)
                    a = {25'b0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
                else
                    a = $urandom | 32'h80;
                xfer(inst, 1'($urandom_range(0, 1)), a, 8'($urandom), {$urandom, $urandom}, -1);
                drain(inst);
            end
        end

        // err_count saturates at 255.
        repeat (260) step(0, 16'h0, 1'b1, 1'b0);
        step(0, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset while instance 0 streams and instance 1 is mid-frame.
        xfer(0, 1'b0, 32'h10, 8'h00, 64'h0, -1);
        repeat (3) step(0, 16'h0, 1'b0, 1'b0);
        step(1, 16'h3, 1'b0, 1'b0);
        step(1, 16'h0010, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("busy0_pre_rst", 64'(busy0), 64'h1);
        chk("busy1_pre_rst", 64'(busy1), 64'h1);
        resetb = 1'b0;
        #1;
        chk("arst_out0", 64'(out0), 64'h0);   chk("arst_pty0", 64'(po0), 64'h1);
        chk("arst_busy0", 64'(busy0), 64'h0); chk("arst_err0", 64'(err0), 64'h0);
        chk("arst_out1", 64'(out1), 64'h0);   chk("arst_pty1", 64'(po1), 64'h1);
        chk("arst_busy1", 64'(busy1), 64'h0);
        repeat (2) @(negedge clk);
        in0 = '0; pi0 = 1'b1; in1 = '0; pi1 = 1'b1;
        resetb = 1'b1;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin em[i] = 0; rs[i] = -100; rl[i] = 0; end

        xfer(1, 1'b1, 32'h30, 8'hFF, 64'h0F1E2D3C4B5A6978, -1); drain(1);
        xfer(1, 1'b0, 32'h30, 8'h00, 64'h0, -1); drain(1);
        step(1, 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
